// File: rtl/mul_arb_pkg.sv
// Shared widths, operand payload type and arbitration helpers for the
// shared-multiplier scheduler.
package mul_arb_pkg;

    localparam int unsigned OPW          = 8;
    localparam int unsigned PRW          = 16;
    localparam int unsigned NREQ_DEFAULT = 4;
    localparam int unsigned NREQ_MAX     = 8;
    localparam int unsigned PTRW_MAX     = 3;

    typedef struct packed {
        logic [OPW-1:0] a;
        logic [OPW-1:0] b;
    } operands_t;

    // First set bit of vld at or after ptr, wrapping modulo nreq; one-hot or zero.
    function automatic logic [NREQ_MAX-1:0] rr_pick(
        input logic [NREQ_MAX-1:0] vld,
        input logic [PTRW_MAX-1:0] ptr,
        input int unsigned         nreq
    );
        logic [NREQ_MAX-1:0] gnt;
        logic                found;
        int unsigned         idx;
        gnt   = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < NREQ_MAX; k++) begin
            idx = (32'(ptr) + k) % nreq;
            if (k < nreq && !found && vld[idx[PTRW_MAX-1:0]]) begin
                gnt[idx[PTRW_MAX-1:0]] = 1'b1;
                found                  = 1'b1;
            end
        end
        return gnt;
    endfunction

    function automatic logic [PTRW_MAX-1:0] oh_to_idx(input logic [NREQ_MAX-1:0] oh);
        logic [PTRW_MAX-1:0] idx;
        idx = '0;
        for (int unsigned i = 0; i < NREQ_MAX; i++) begin
            if (oh[i]) begin
                idx = idx | PTRW_MAX'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/mul_subexpression_dsr.sv
// Combinational 8x8 unsigned multiplier with full-width product.
module mul_subexpression_dsr
    import mul_arb_pkg::*;
(
    input  logic [OPW-1:0] a_i,
    input  logic [OPW-1:0] b_i,
    output logic [PRW-1:0] product_o
);

    assign product_o = PRW'(a_i) * PRW'(b_i);

endmodule

// File: rtl/mul_share_arb.sv
// Round-robin scheduler sharing one multiplier among NREQ requesters through
// an operand stage and a product stage, with full response backpressure.
module mul_share_arb
    import mul_arb_pkg::*;
#(
    parameter int unsigned NREQ = NREQ_DEFAULT,
    parameter int unsigned IDW  = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*OPW-1:0]  req_a,
    input  logic [NREQ*OPW-1:0]  req_b,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [IDW-1:0]       rsp_id,
    output logic [PRW-1:0]       rsp_product
);

    logic                s1_valid_q, s1_valid_d;
    operands_t           s1_ops_q, s1_ops_d;
    logic [IDW-1:0]      s1_id_q, s1_id_d;
    logic                s2_valid_q, s2_valid_d;
    logic [PRW-1:0]      s2_product_q, s2_product_d;
    logic [IDW-1:0]      s2_id_q, s2_id_d;
    logic [IDW-1:0]      ptr_q, ptr_d;

    logic                stall_c;
    logic                adv_c;
    logic                grant_en_c;
    logic                any_gnt_c;
    logic [NREQ_MAX-1:0] pick_c;
    logic [PTRW_MAX-1:0] gnt_idx_c;
    logic [PRW-1:0]      mul_p_c;

    // Stages only freeze when both are full and the consumer refuses.
    assign stall_c    = s2_valid_q & ~rsp_ready & s1_valid_q;
    assign adv_c      = ~s2_valid_q | rsp_ready;
    assign grant_en_c = rst_n & ~stall_c;

    assign pick_c    = rr_pick(NREQ_MAX'(req_valid), PTRW_MAX'(ptr_q), NREQ);
    assign any_gnt_c = |pick_c;
    assign gnt_idx_c = oh_to_idx(pick_c);
    assign req_ready = grant_en_c ? pick_c[NREQ-1:0] : '0;

    mul_subexpression_dsr u_mul (
        .a_i       (s1_ops_q.a),
        .b_i       (s1_ops_q.b),
        .product_o (mul_p_c)
    );

    always_comb begin
        s1_valid_d   = s1_valid_q;
        s1_ops_d     = s1_ops_q;
        s1_id_d      = s1_id_q;
        s2_valid_d   = s2_valid_q;
        s2_product_d = s2_product_q;
        s2_id_d      = s2_id_q;
        ptr_d        = ptr_q;

        // s1 is free (empty or moving on): take a new grant or go empty.
        if (!stall_c) begin
            s1_valid_d = any_gnt_c;
            if (any_gnt_c) begin
                s1_ops_d.a = req_a[32'(gnt_idx_c)*OPW +: OPW];
                s1_ops_d.b = req_b[32'(gnt_idx_c)*OPW +: OPW];
                s1_id_d    = IDW'(gnt_idx_c);
                ptr_d      = IDW'((32'(gnt_idx_c) + 32'd1) % NREQ);
            end
        end

        // Data only reloads on a real transfer so the response holds otherwise.
        if (adv_c) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_product_d = mul_p_c;
                s2_id_d      = s1_id_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q   <= 1'b0;
            s1_ops_q     <= '0;
            s1_id_q      <= '0;
            s2_valid_q   <= 1'b0;
            s2_product_q <= '0;
            s2_id_q      <= '0;
            ptr_q        <= '0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_ops_q     <= s1_ops_d;
            s1_id_q      <= s1_id_d;
            s2_valid_q   <= s2_valid_d;
            s2_product_q <= s2_product_d;
            s2_id_q      <= s2_id_d;
            ptr_q        <= ptr_d;
        end
    end

    assign rsp_valid   = s2_valid_q;
    assign rsp_product = s2_product_q;
    assign rsp_id      = s2_id_q;

endmodule

// File: tb/tb_mul_share_arb.sv
// Self-checking bench for mul_share_arb: directed scenarios plus a random soak
// against a queue-based model of the two-slot pipeline.
module tb_mul_share_arb;

    localparam int unsigned NREQ = 4;

    logic             clk;
    logic             rst_n;
    logic [NREQ-1:0]  req_valid;
    logic [NREQ-1:0]  req_ready;
    logic [NREQ*8-1:0] req_a;
    logic [NREQ*8-1:0] req_b;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [1:0]       rsp_id;
    logic [15:0]      rsp_product;

    mul_share_arb #(.NREQ(NREQ)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_a       (req_a),
        .req_b       (req_b),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_id      (rsp_id),
        .rsp_product (rsp_product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Requester-side stimulus state
    bit         v [NREQ];
    logic [7:0] a [NREQ];
    logic [7:0] b [NREQ];

    always_comb begin
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_valid[i]       = v[i];
            req_a[i*8 +: 8]    = a[i];
            req_b[i*8 +: 8]    = b[i];
        end
    end

    // Reference model: in-flight items in order, each tagged with its stage
    typedef struct {
        int          id;
        logic [15:0] prod;
        int          stage;
    } item_t;

    item_t pipe [$];
    int    ptr_m;
    int    waits [NREQ];
    int    last_gnt;
    int    obs_gnt [$];
    int    obs_id [$];
    int    obs_prod [$];

    int checks = 0;
    int errors = 0;

    task automatic model_reset();
        pipe.delete();
        ptr_m = 0;
        for (int i = 0; i < NREQ; i++) waits[i] = 0;
    endtask

    task automatic clear_obs();
        obs_gnt.delete();
        obs_id.delete();
        obs_prod.delete();
    endtask

    // One clock: check outputs mid-cycle against the model, then advance the model.
    task automatic step();
        int              win;
        int              dut_g;
        bit              has1, has2, allow;
        logic [NREQ-1:0] exp_rdy;
        item_t           it;
        @(negedge clk);
        has2  = (pipe.size() > 0) && (pipe[0].stage == 2);
        has1  = (pipe.size() > 0) && (pipe[pipe.size()-1].stage == 1);
        allow = !(has1 && has2 && !rsp_ready);
        win   = -1;
        for (int k = 0; k < NREQ; k++) begin
            int idx;
            idx = (ptr_m + k) % NREQ;
            if (win < 0 && v[idx]) win = idx;
        end
        if (!allow) win = -1;
        exp_rdy = '0;
        if (win >= 0) exp_rdy[win] = 1'b1;

        checks++;
        if (req_ready !== exp_rdy) begin
            errors++;
            $display("FAIL req_ready got %b exp %b t=%0t", req_ready, exp_rdy, $time);
        end
        checks++;
        if (rsp_valid !== 1'(has2)) begin
            errors++;
            $display("FAIL rsp_valid got %b exp %b t=%0t", rsp_valid, has2, $time);
        end
        if (has2) begin
            checks++;
            if (rsp_id !== 2'(pipe[0].id)) begin
                errors++;
                $display("FAIL rsp_id got %0d exp %0d t=%0t", rsp_id, pipe[0].id, $time);
            end
            checks++;
            if (rsp_product !== pipe[0].prod) begin
                errors++;
                $display("FAIL rsp_product got %h exp %h t=%0t", rsp_product, pipe[0].prod, $time);
            end
        end
        if (rsp_valid === 1'b1 && rsp_ready) begin
            obs_id.push_back(int'(rsp_id));
            obs_prod.push_back(int'(rsp_product));
        end

        dut_g = -1;
        for (int i = 0; i < NREQ; i++) if (req_ready[i] === 1'b1) dut_g = i;
        if (dut_g >= 0) obs_gnt.push_back(dut_g);
        for (int i = 0; i < NREQ; i++) begin
            if (!v[i] || dut_g == i) waits[i] = 0;
            else if (dut_g >= 0) waits[i]++;
            if (v[i]) begin
                checks++;
                if (waits[i] > NREQ - 1) begin
                    errors++;
                    $display("FAIL fairness req %0d waited %0d grants, max %0d", i, waits[i], NREQ - 1);
                end
            end
        end

        if (has2 && rsp_ready) void'(pipe.pop_front());
        if (!has2 || rsp_ready) begin
            for (int i = 0; i < pipe.size(); i++) pipe[i].stage = 2;
        end
        if (win >= 0) begin
            it.id    = win;
            it.prod  = 16'(a[win]) * 16'(b[win]);
            it.stage = 1;
            pipe.push_back(it);
            ptr_m = (win + 1) % NREQ;
        end
        last_gnt = win;
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < NREQ; i++) v[i] = 1'b0;
        rsp_ready = 1'b1;
        repeat (n) step();
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        rsp_ready = 1'b1;
        for (int i = 0; i < NREQ; i++) begin
            v[i] = 1'b1;
            a[i] = 8'($urandom);
            b[i] = 8'($urandom);
        end
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (req_ready !== '0) begin errors++; $display("FAIL reset_req_ready got %b exp 0", req_ready); end
        checks++;
        if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b exp 0", rsp_valid); end
        checks++;
        if (rsp_product !== 16'h0) begin errors++; $display("FAIL reset_rsp_product got %h exp 0", rsp_product); end
        checks++;
        if (rsp_id !== 2'd0) begin errors++; $display("FAIL reset_rsp_id got %0d exp 0", rsp_id); end
        for (int i = 0; i < NREQ; i++) v[i] = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic test_round_robin();
        int exp_id [5];
        int exp_pr [5];
        exp_id = '{0, 1, 2, 3, 0};
        exp_pr = '{3, 6, 9, 12, 3};
        clear_obs();
        rsp_ready = 1'b1;
        for (int i = 0; i < NREQ; i++) begin
            v[i] = 1'b1;
            a[i] = 8'(i + 1);
            b[i] = 8'd3;
        end
        repeat (5) step();
        drain(3);
        checks++;
        if (obs_gnt.size() != 5 || obs_id.size() != 5) begin
            errors++;
            $display("FAIL rr_count grants %0d rsps %0d exp 5", obs_gnt.size(), obs_id.size());
        end
        for (int k = 0; k < 5; k++) begin
            if (k < obs_gnt.size()) begin
                checks++;
                if (obs_gnt[k] != exp_id[k]) begin
                    errors++;
                    $display("FAIL rr_grant[%0d] got %0d exp %0d", k, obs_gnt[k], exp_id[k]);
                end
            end
            if (k < obs_id.size()) begin
                checks++;
                if (obs_id[k] != exp_id[k] || obs_prod[k] != exp_pr[k]) begin
                    errors++;
                    $display("FAIL rr_rsp[%0d] got id %0d prod %0d exp id %0d prod %0d",
                             k, obs_id[k], obs_prod[k], exp_id[k], exp_pr[k]);
                end
            end
        end
    endtask

    task automatic test_single();
        rsp_ready = 1'b1;
        v[2] = 1'b1;
        a[2] = 8'hFF;
        b[2] = 8'hFF;
        step();
        checks++;
        if (last_gnt != 2) begin errors++; $display("FAIL single_grant model winner %0d exp 2", last_gnt); end
        v[2] = 1'b0;
        step();
        checks++;
        if (rsp_valid !== 1'b1 || rsp_product !== 16'hFE01 || rsp_id !== 2'd2) begin
            errors++;
            $display("FAIL single_rsp got v%b p%h id%0d exp v1 pFE01 id2", rsp_valid, rsp_product, rsp_id);
        end
        drain(2);
    endtask

    task automatic test_backpressure();
        int          grants;
        logic [15:0] first_prod;
        clear_obs();
        grants     = 0;
        first_prod = 16'h0;
        rsp_ready  = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            v[i] = 1'b1;
            a[i] = 8'($urandom);
            b[i] = 8'($urandom);
        end
        repeat (5) begin
            step();
            if (last_gnt >= 0) begin
                if (grants == 0) first_prod = 16'(a[last_gnt]) * 16'(b[last_gnt]);
                grants++;
                a[last_gnt] = 8'($urandom);
                b[last_gnt] = 8'($urandom);
            end
        end
        checks++;
        if (obs_gnt.size() != 2) begin
            errors++;
            $display("FAIL bp_accepts got %0d exp 2", obs_gnt.size());
        end
        checks++;
        if (rsp_valid !== 1'b1 || rsp_product !== first_prod) begin
            errors++;
            $display("FAIL bp_hold got v%b p%h exp v1 p%h", rsp_valid, rsp_product, first_prod);
        end
        rsp_ready = 1'b1;
        step();
        checks++;
        if (obs_gnt.size() != 3) begin
            errors++;
            $display("FAIL bp_resume accepts got %0d exp 3", obs_gnt.size());
        end
        if (last_gnt >= 0) grants++;
        repeat (4) begin
            step();
            if (last_gnt >= 0) grants++;
        end
        drain(4);
        checks++;
        if (obs_id.size() != grants) begin
            errors++;
            $display("FAIL bp_drain responses got %0d exp %0d", obs_id.size(), grants);
        end
    endtask

    task automatic test_pointer_hold();
        clear_obs();
        rsp_ready = 1'b1;
        v[3] = 1'b1; a[3] = 8'd7; b[3] = 8'd9;
        step();
        v[3] = 1'b0;
        repeat (2) step();
        v[1] = 1'b1; a[1] = 8'd5; b[1] = 8'd11;
        step();
        v[1] = 1'b0;
        repeat (3) step();
        v[1] = 1'b1; v[2] = 1'b1; a[2] = 8'd2; b[2] = 8'd200;
        step();
        v[2] = 1'b0;
        step();
        v[1] = 1'b0;
        drain(3);
        checks++;
        if (obs_gnt.size() != 4) begin
            errors++;
            $display("FAIL ptr_count grants %0d exp 4", obs_gnt.size());
        end else begin
            checks++;
            if (obs_gnt[0] != 3 || obs_gnt[1] != 1 || obs_gnt[2] != 2 || obs_gnt[3] != 1) begin
                errors++;
                $display("FAIL ptr_order got %0d %0d %0d %0d exp 3 1 2 1",
                         obs_gnt[0], obs_gnt[1], obs_gnt[2], obs_gnt[3]);
            end
        end
    endtask

    task automatic test_reset_midstream();
        rsp_ready = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            v[i] = 1'b1;
            a[i] = 8'($urandom);
            b[i] = 8'($urandom);
        end
        repeat (3) step();
        rst_n = 1'b0;
        #1;
        checks++;
        if (rsp_valid !== 1'b0 || req_ready !== '0) begin
            errors++;
            $display("FAIL midreset got rsp_valid %b req_ready %b exp 0 0", rsp_valid, req_ready);
        end
        checks++;
        if (rsp_product !== 16'h0 || rsp_id !== 2'd0) begin
            errors++;
            $display("FAIL midreset_data got p%h id%0d exp 0 0", rsp_product, rsp_id);
        end
        model_reset();
        for (int i = 0; i < NREQ; i++) v[i] = 1'b0;
        v[1] = 1'b1;
        v[3] = 1'b1;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        clear_obs();
        step();
        checks++;
        if (obs_gnt.size() != 1 || obs_gnt[0] != 1) begin
            errors++;
            $display("FAIL post_reset_grant got %0d grants first %0d exp 1",
                     obs_gnt.size(), (obs_gnt.size() > 0) ? obs_gnt[0] : -1);
        end
        v[1] = 1'b0;
        step();
        v[3] = 1'b0;
        drain(3);
    endtask

    task automatic test_soak();
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!v[i] && ($urandom % 2 == 0)) begin
                    v[i] = 1'b1;
                    a[i] = 8'($urandom);
                    b[i] = 8'($urandom);
                end
            end
            rsp_ready = ($urandom % 4) != 0;
            step();
            if (last_gnt >= 0) begin
                if ($urandom % 2 == 0) begin
                    v[last_gnt] = 1'b0;
                end else begin
                    a[last_gnt] = 8'($urandom);
                    b[last_gnt] = 8'($urandom);
                end
            end
        end
        drain(4);
    endtask

    initial begin
        rst_n     = 1'b0;
        rsp_ready = 1'b0;
        last_gnt  = -1;
        for (int i = 0; i < NREQ; i++) begin
            v[i] = 1'b0;
            a[i] = 8'h0;
            b[i] = 8'h0;
        end
        test_reset();
        test_round_robin();
        test_single();
        test_backpressure();
        test_pointer_hold();
        test_reset_midstream();
        test_soak();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mul_share_arb.md
# mul_share_arb

Round-robin scheduler that shares one combinational 8x8 unsigned multiplier among NREQ requesters. It has a valid/ready request port per requester and one tagged valid/ready response port. A two-stage registered pipeline (operand register, then product register) wraps the combinational multiplier. Sustained throughput is one product per cycle, with full backpressure from the response side.

## Interface
- NREQ, 4: number of requesters, 2..8.
- IDW, $clog2(NREQ): width of the requester ID tag.

- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- req_valid  input  NREQ  per-requester request valid.
- req_ready  output  NREQ  per-requester grant/accept, one-hot or zero.
- req_a  input  NREQ*8  multiplicand, requester i in bits [8i+7:8i].
- req_b  input  NREQ*8  multiplier, requester i in bits [8i+7:8i].
- rsp_valid  output  1  product available.
- rsp_ready  input  1  consumer accepts product.
- rsp_id  output  IDW  index of the requester that owns rsp_product.
- rsp_product  output  16  unsigned a*b.

## Operation
- Acceptance: requester i is accepted when req_valid[i] & req_ready[i]. At most one acceptance per cycle.
- req_ready is combinational from req_valid, the pointer and the stall term.
  - Requesters must not gate req_valid on req_ready.
  - Once asserted, req_valid and its operands are held until accepted.
- Arbitration: rotating pointer ptr (IDW bits).
  - Search req_valid starting at ptr, wrapping modulo NREQ. The first set bit wins.
  - After a grant to i, ptr becomes (i+1) mod NREQ.
  - ptr is unchanged in cycles with no grant.
- Stall: stall = s2_valid & ~rsp_ready & s1_valid.
  - While stall is high, req_ready is all zero and both stages hold.
  - Advance (bubble squeeze): s1 moves into s2 whenever s2 is empty or being drained (~s2_valid | rsp_ready).
  - A new grant occurs whenever s1 is empty or moving.
- Stage 1 registers: s1_valid, s1_a, s1_b, s1_id.
- Stage 2 registers: s2_valid, s2_product = s1_a*s1_b, s2_id. The product comes from the combinational multiplier instance.
- Output mapping: rsp_valid = s2_valid, rsp_product = s2_product, rsp_id = s2_id.
- Arithmetic: unsigned and full width. No truncation is possible (max 255*255 = 0xFE01).
- Reset (asynchronous, any time) drops all in-flight work. It clears:
  - s1_valid, s2_valid, ptr to 0;
  - s1/s2 data and IDs to 0.
  - Consequently rsp_valid = 0, rsp_product = 0, rsp_id = 0, and req_ready = 0 while rst_n is low.
- Response rule: rsp_product and rsp_id are held stable while rsp_valid & ~rsp_ready.

## Timing
- Latency: a request accepted in cycle t gives rsp_valid in cycle t+2 if there is no backpressure.
- Throughput: one accept per cycle while rsp_ready is held high.
- Backpressure:
  - With rsp_ready low, two products can be buffered (s1 and s2). The third request is refused.
  - When rsp_ready rises, acceptance resumes in the same cycle.
- Simultaneous events:
  - Drain of s2 and acceptance into s1 in the same cycle are both legal.
  - When all requesters are continuously valid, grants go 0,1,...,NREQ-1,0.
- Fairness: no requester waits more than NREQ-1 grants once valid.
- The critical path is the s1 registers through the multiplier to s2. No other logic sits in that path.

## Structure
- Package mul_arb_pkg:
  - OPW = 8, PRW = 16;
  - default NREQ;
  - round-robin pick function (valid vector and pointer in, one-hot grant out).
- Sub-module: one instance of the team's combinational 8x8 multiplier, mul_subexpression_dsr, between stage 1 and stage 2.
- Arbiter, pointer and pipeline registers are top-level always_ff/always_comb logic. No separate FSM module is used. Pipeline state is implied by {s1_valid, s2_valid}: EMPTY, ONE, FULL.

## Test plan
- Reset: assert rst_n=0 mid-stream with s1 and s2 full -> rsp_valid=0, req_ready=0 immediately. After release, the first grant goes to the lowest-index valid requester.
- Single request: req 2 sends a=0xFF, b=0xFF with rsp_ready=1 -> cycle t+2 shows rsp_valid=1, rsp_product=0xFE01, rsp_id=2.
- Round robin: all four requesters valid with a=i+1, b=3 -> responses with IDs 0,1,2,3,0 and products 3,6,9,12,3, one per cycle.
- Backpressure: rsp_ready=0 with all requesters valid -> exactly two accepts, then req_ready=0 and the output is stable. Raising rsp_ready -> in-order drain with no loss or duplication.
- Pointer hold: only req 3 valid, then only req 1 -> grants 3 then 1. ptr = 2 after the second grant, unchanged over idle cycles.
- Random soak: random valids, operands and rsp_ready -> every response matches a scoreboard of a*b per ID, and no requester exceeds NREQ-1 grants of wait.
